// File: rtl/register_file_multiport_pkg.sv
// Shared constants and the byte-lane merge used by both the write path and the read bypass.
package regfile_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 5;
    localparam int unsigned DEF_READ_PORTS = 2;
    localparam int unsigned BYTES          = DEF_DATA_WIDTH / 8;
    localparam int unsigned MAX_DATA_WIDTH = 256;
    localparam int unsigned MAX_BYTES      = MAX_DATA_WIDTH / 8;

    // Lanes with en=1 take new_v, the rest keep old_v; callers zero-extend to MAX width.
    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_v,
        input logic [MAX_DATA_WIDTH-1:0] new_v,
        input logic [MAX_BYTES-1:0]      en
    );
        logic [MAX_DATA_WIDTH-1:0] res;
        res = old_v;
        for (int unsigned b = 0; b < MAX_BYTES; b++) begin
            if (en[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/register_file_multiport_if.sv
// Decode/writeback bus of the multiport register file.
interface register_file_multiport_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned READ_PORTS = DEF_READ_PORTS
) ();
    localparam int unsigned LANES = DATA_WIDTH / 8;

    logic [READ_PORTS*ADDR_WIDTH-1:0] read_index;
    logic [READ_PORTS*DATA_WIDTH-1:0] read_data;
    logic [READ_PORTS-1:0]            read_pending;
    logic                             wa_enable;
    logic [ADDR_WIDTH-1:0]            wa_reg;
    logic [DATA_WIDTH-1:0]            wa_data;
    logic [LANES-1:0]                 wa_byte_en;
    logic                             wb_enable;
    logic [ADDR_WIDTH-1:0]            wb_reg;
    logic [DATA_WIDTH-1:0]            wb_data;
    logic [LANES-1:0]                 wb_byte_en;
    logic                             pend_set;
    logic [ADDR_WIDTH-1:0]            pend_reg;
    logic [DATA_WIDTH-1:0]            debug_reg;

    modport master (
        output read_index, wa_enable, wa_reg, wa_data, wa_byte_en,
               wb_enable, wb_reg, wb_data, wb_byte_en, pend_set, pend_reg,
        input  read_data, read_pending, debug_reg
    );

    modport slave (
        input  read_index, wa_enable, wa_reg, wa_data, wa_byte_en,
               wb_enable, wb_reg, wb_data, wb_byte_en, pend_set, pend_reg,
        output read_data, read_pending, debug_reg
    );
endinterface

// File: rtl/register_file_multiport_scoreboard.sv
// Per-register "load outstanding" bits; a new load issued in the clearing cycle wins.
module regfile_scoreboard #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned READ_PORTS = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             pend_set,
    input  logic [ADDR_WIDTH-1:0]            pend_reg,
    input  logic                             clr_en,
    input  logic [ADDR_WIDTH-1:0]            clr_reg,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] read_index,
    output logic [READ_PORTS-1:0]            read_pending_c
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    always_comb begin
        pend_d = pend_q;
        if (clr_en) pend_d[clr_reg] = 1'b0;
        if (pend_set) pend_d[pend_reg] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    // A writeback landing this cycle hides the bit so decode can proceed on bypassed data.
    for (genvar p = 0; p < READ_PORTS; p++) begin : g_lookup
        logic [ADDR_WIDTH-1:0] idx;
        assign idx = read_index[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign read_pending_c[p] = pend_q[idx] & ~(clr_en && (clr_reg == idx) && (idx != '0));
    end
endmodule

// File: rtl/register_file_multiport.sv
// Register file with two byte-enabled write ports, bypassed read ports and a load scoreboard.
module register_file_multiport
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned READ_PORTS  = DEF_READ_PORTS,
    parameter int unsigned DEBUG_INDEX = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    register_file_multiport_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned LANES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];

    // Apply this cycle's port B then port A lanes to old_v, so A wins on shared lanes.
    function automatic logic [DATA_WIDTH-1:0] merged_word(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [ADDR_WIDTH-1:0] idx
    );
        logic [LANES-1:0]      a_en;
        logic [LANES-1:0]      b_en;
        logic [DATA_WIDTH-1:0] w;
        a_en = (bus.wa_enable && (bus.wa_reg == idx) && (idx != '0)) ? bus.wa_byte_en : '0;
        b_en = (bus.wb_enable && (bus.wb_reg == idx) && (idx != '0)) ? bus.wb_byte_en : '0;
        w = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(old_v), MAX_DATA_WIDTH'(bus.wb_data),
                                   MAX_BYTES'(b_en)));
        w = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(w), MAX_DATA_WIDTH'(bus.wa_data),
                                   MAX_BYTES'(a_en)));
        return w;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_d[i] = merged_word(regs_q[i], ADDR_WIDTH'(i));
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (reset) regs_q[i] <= '0;
            else       regs_q[i] <= regs_d[i];
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] idx;
        assign idx = bus.read_index[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign bus.read_data[p*DATA_WIDTH +: DATA_WIDTH] =
            reset ? regs_q[idx] : merged_word(regs_q[idx], idx);
    end

    assign bus.debug_reg = regs_q[ADDR_WIDTH'(DEBUG_INDEX)];

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .READ_PORTS (READ_PORTS)
    ) u_scoreboard (
        .clk            (clk),
        .reset          (reset),
        .pend_set       (bus.pend_set),
        .pend_reg       (bus.pend_reg),
        .clr_en         (bus.wb_enable),
        .clr_reg        (bus.wb_reg),
        .read_index     (bus.read_index),
        .read_pending_c (bus.read_pending)
    );
endmodule
